// File: rtl/color_write_ctrl_pkg.sv
// Shared types and constants for the colour lookup-table write controller.
package color_pkg;

  localparam int         NUM_COLORS       = 32;
  localparam logic [7:0] COLOR_BASE_WADDR = 8'hC0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [11:0] rgb;
  } color_wr_t;

  typedef enum logic {INIT, RUN} state_t;

  // COLOR00..COLOR31 occupy one aligned 32-word window of the register map.
  function automatic logic is_color_addr(input logic [7:0] addr);
    return addr[7:5] == COLOR_BASE_WADDR[7:5];
  endfunction

endpackage

// File: rtl/color_write_ctrl_if.sv
// Register-bus, pixel-read and table-write signals of the colour write controller.
interface color_write_ctrl_if;

  logic        rga_wr;
  logic [7:0]  rga_addr;
  logic [15:0] rga_data;
  logic        pix_rd;
  logic        tbl_wr;
  logic [4:0]  tbl_idx;
  logic [11:0] tbl_rgb;
  logic        init_busy;
  logic        fifo_full;
  logic        drop;

  modport master (
    output rga_wr, rga_addr, rga_data, pix_rd,
    input  tbl_wr, tbl_idx, tbl_rgb, init_busy, fifo_full, drop
  );

  modport slave (
    input  rga_wr, rga_addr, rga_data, pix_rd,
    output tbl_wr, tbl_idx, tbl_rgb, init_busy, fifo_full, drop
  );

endinterface

// File: rtl/color_write_ctrl_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push and pop may coincide even when full.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/color_write_ctrl.sv
// Colour table write port: reset sweep, then buffered register writes drained
// whenever the pixel pipeline leaves the table free.
module color_write_ctrl
  import color_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [11:0] INIT_RGB    = 12'h000,
  parameter bit          DEFER_ON_RD = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  color_write_ctrl_if.slave bus
);

  localparam int W = $bits(color_wr_t);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        tbl_wr_q, tbl_wr_d;
  logic [4:0]  tbl_idx_q, tbl_idx_d;
  logic [11:0] tbl_rgb_q, tbl_rgb_d;
  logic        init_busy_q, init_busy_d;
  logic        drop_q, drop_d;

  logic        hit, pop_ok, bypass;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0] head_bits;
  color_wr_t   new_entry, head;
  logic        unused_data_hi;

  assign hit            = bus.rga_wr & is_color_addr(bus.rga_addr);
  assign new_entry      = '{idx: bus.rga_addr[4:0], rgb: bus.rga_data[11:0]};
  assign head           = color_wr_t'(head_bits);
  assign unused_data_hi = ^bus.rga_data[15:12];

  sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (new_entry),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An empty FIFO hands a hit straight to the output register so it still lands one cycle later.
  always_comb begin
    pop_ok    = (state_q == RUN) && (!DEFER_ON_RD || !bus.pix_rd);
    fifo_pop  = pop_ok && !fifo_empty;
    bypass    = pop_ok && fifo_empty && hit;
    fifo_push = hit && !bypass && (!fifo_full || fifo_pop);
    drop_d    = hit && fifo_full && !fifo_pop;

    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    tbl_wr_d    = 1'b0;
    tbl_idx_d   = tbl_idx_q;
    tbl_rgb_d   = tbl_rgb_q;

    case (state_q)
      INIT: begin
        tbl_wr_d  = 1'b1;
        tbl_idx_d = cnt_q;
        tbl_rgb_d = INIT_RGB;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'(NUM_COLORS - 1)) begin
          state_d     = RUN;
          init_busy_d = 1'b0;
        end
      end
      RUN: begin
        if (fifo_pop) begin
          tbl_wr_d  = 1'b1;
          tbl_idx_d = head.idx;
          tbl_rgb_d = head.rgb;
        end else if (bypass) begin
          tbl_wr_d  = 1'b1;
          tbl_idx_d = new_entry.idx;
          tbl_rgb_d = new_entry.rgb;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      tbl_wr_q    <= 1'b0;
      tbl_idx_q   <= '0;
      tbl_rgb_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      tbl_wr_q    <= tbl_wr_d;
      tbl_idx_q   <= tbl_idx_d;
      tbl_rgb_q   <= tbl_rgb_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.tbl_wr    = tbl_wr_q;
  assign bus.tbl_idx   = tbl_idx_q;
  assign bus.tbl_rgb   = tbl_rgb_q;
  assign bus.init_busy = init_busy_q;
  assign bus.fifo_full = fifo_full;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_color_write_ctrl.sv
// Directed bench for color_write_ctrl; table writes are matched in order against a queue of expected entries.
module tb_color_write_ctrl;
  import color_pkg::*;

  localparam logic [11:0] INIT_RGB = 12'h000;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   testsFailed = 0;
  color_wr_t sb[$];

  color_write_ctrl_if bus();

  color_write_ctrl #(
    .FIFO_DEPTH  (4),
    .INIT_RGB    (INIT_RGB),
    .DEFER_ON_RD (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [15:0] data, input logic pix);
    bus.rga_wr   = wr;
    bus.rga_addr = addr;
    bus.rga_data = data;
    bus.pix_rd   = pix;
  endtask

  function automatic color_wr_t mkEntry(input logic [4:0] idx, input logic [11:0] rgb);
    color_wr_t e;
    e.idx = idx;
    e.rgb = rgb;
    return e;
  endfunction

  task automatic expectSweep();
    for (int i = 0; i < 32; i++) sb.push_back(mkEntry(5'(i), INIT_RGB));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tbl_wr"}, 32'(bus.tbl_wr), 32'd0);
    checkOutput({tag, "_tbl_idx"}, 32'(bus.tbl_idx), 32'd0);
    checkOutput({tag, "_tbl_rgb"}, 32'(bus.tbl_rgb), 32'd0);
    checkOutput({tag, "_init_busy"}, 32'(bus.init_busy), 32'd1);
    checkOutput({tag, "_fifo_full"}, 32'(bus.fifo_full), 32'd0);
    checkOutput({tag, "_drop"}, 32'(bus.drop), 32'd0);
  endtask

  // Every visible table write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    color_wr_t e;
    if (rst_n === 1'b1 && bus.tbl_wr === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("wr_unexpected", 32'(bus.tbl_wr), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_idx", 32'(bus.tbl_idx), 32'(e.idx));
        checkOutput("wr_rgb", 32'(bus.tbl_rgb), 32'(e.rgb));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    checkResetValues("reset");

    expectSweep();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checkOutput("init_wr", 32'(bus.tbl_wr), 32'd1);
      checkOutput("init_idx", 32'(bus.tbl_idx), 32'(i));
      checkOutput("init_busy", 32'(bus.init_busy), (i < 31) ? 32'd1 : 32'd0);
      checkOutput("init_drop", 32'(bus.drop), 32'd0);
      if (i == 3) begin
        applyStimulus(1'b1, 8'hC7, 16'h50F0, 1'b0);
        sb.push_back(mkEntry(5'd7, 12'h0F0));
      end else begin
        applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0);
      end
    end

    @(negedge clk);
    checkOutput("init_hit_wr", 32'(bus.tbl_wr), 32'd1);
    checkOutput("init_hit_idx", 32'(bus.tbl_idx), 32'd7);
    checkOutput("init_hit_rgb", 32'(bus.tbl_rgb), 32'h0F0);
    checkOutput("busy_low", 32'(bus.init_busy), 32'd0);

    applyStimulus(1'b1, 8'hC5, 16'hFABC, 1'b0);
    sb.push_back(mkEntry(5'd5, 12'hABC));
    @(negedge clk);
    checkOutput("lat_wr", 32'(bus.tbl_wr), 32'd1);
    checkOutput("lat_idx", 32'(bus.tbl_idx), 32'd5);
    checkOutput("lat_rgb", 32'(bus.tbl_rgb), 32'hABC);

    applyStimulus(1'b1, 8'hBF, 16'h0123, 1'b0);
    @(negedge clk);
    checkOutput("miss_bf_wr", 32'(bus.tbl_wr), 32'd0);
    checkOutput("hold_idx", 32'(bus.tbl_idx), 32'd5);
    applyStimulus(1'b1, 8'hE0, 16'h0456, 1'b0);
    @(negedge clk);
    checkOutput("miss_e0_wr", 32'(bus.tbl_wr), 32'd0);
    checkOutput("hold_rgb", 32'(bus.tbl_rgb), 32'hABC);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 8'hC0 | 8'(k), {4'hF, 4'(k), 8'h5A}, 1'b1);
      sb.push_back(mkEntry(5'(k), {4'(k), 8'h5A}));
      @(negedge clk);
      checkOutput("defer_wr", 32'(bus.tbl_wr), 32'd0);
      checkOutput("defer_full", 32'(bus.fifo_full), (k == 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 8'hC6, 16'h0666, 1'b1);
    @(negedge clk);
    checkOutput("drop_pulse", 32'(bus.drop), 32'd1);
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("drop_clear", 32'(bus.drop), 32'd0);
    checkOutput("still_full", 32'(bus.fifo_full), 32'd1);

    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("drain_wr", 32'(bus.tbl_wr), 32'd1);
      checkOutput("drain_idx", 32'(bus.tbl_idx), 32'(k));
    end
    @(negedge clk);
    checkOutput("drain_done", 32'(bus.tbl_wr), 32'd0);
    checkOutput("drain_not_full", 32'(bus.fifo_full), 32'd0);

    for (int k = 10; k <= 13; k++) begin
      applyStimulus(1'b1, 8'hC0 | 8'(k), {4'h0, 12'(k * 12'h111)}, 1'b1);
      sb.push_back(mkEntry(5'(k), 12'(k * 12'h111)));
      @(negedge clk);
    end
    checkOutput("refill_full", 32'(bus.fifo_full), 32'd1);
    applyStimulus(1'b1, 8'hC9, 16'h0999, 1'b0);
    sb.push_back(mkEntry(5'd9, 12'h999));
    @(negedge clk);
    checkOutput("simul_no_drop", 32'(bus.drop), 32'd0);
    checkOutput("simul_wr", 32'(bus.tbl_wr), 32'd1);
    checkOutput("simul_idx", 32'(bus.tbl_idx), 32'd10);
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput("simul_drain_wr", 32'(bus.tbl_wr), 32'd1);
    end
    checkOutput("idx9_fifth", 32'(bus.tbl_idx), 32'd9);
    @(negedge clk);
    checkOutput("simul_done", 32'(bus.tbl_wr), 32'd0);

    for (int k = 20; k <= 22; k++) begin
      applyStimulus(1'b1, 8'hC0 | 8'(k), 16'h0200 | 16'(k), 1'b1);
      sb.push_back(mkEntry(5'(k), 12'h200 | 12'(k)));
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("middrain_idx", 32'(bus.tbl_idx), 32'd20);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkResetValues("async_reset");

    @(negedge clk);
    expectSweep();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checkOutput("resweep_wr", 32'(bus.tbl_wr), 32'd1);
      checkOutput("resweep_idx", 32'(bus.tbl_idx), 32'(i));
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput("stale_wr", 32'(bus.tbl_wr), 32'd0);
    end
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/color_write_ctrl.md
Name: color_write_ctrl

Overview:
Owns the write port of the 32-entry colour lookup table (12-bit RGB per entry). It decodes register-bus writes to COLOR00..COLOR31 and buffers them in a small FIFO. It drains the FIFO into the table only when the display pipeline is not reading, so table writes are deferred out of display reads. After reset it runs an initialisation sweep that loads every entry with a default colour. It sits between the register-bus decoder and the colour table, beside the pixel pipeline's read port.

Parameters:
FIFO_DEPTH, 4, write-buffer entries; power of two, 2..16.
INIT_RGB, 12'h000, value loaded into all 32 entries by the reset sweep.
DEFER_ON_RD, 1, 1 = drain only when pix_rd is low; 0 = drain every cycle.

Ports:
clk  in  1  system clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
rga_wr  in  1  register-bus write strobe, one cycle per write.
rga_addr  in  8  register word address (byte address >> 1); COLORxx = 8'hC0..8'hDF.
rga_data  in  16  write data; bits [11:0] used, [15:12] ignored.
pix_rd  in  1  display pipeline reads the table this cycle.
tbl_wr  out  1  table write enable.
tbl_idx  out  5  table write index.
tbl_rgb  out  12  table write data.
init_busy  out  1  high while the reset sweep runs.
fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
drop  out  1  one-cycle pulse when an accepted-address write is lost to a full FIFO.

Behaviour:
- Reset (rst_n low, async): state=INIT, sweep counter=0, FIFO empty, init_busy=1, tbl_wr=0, tbl_idx=0, tbl_rgb=0, fifo_full=0, drop=0.
- Decode: hit = rga_wr & (rga_addr[7:5]==3'b110). Index = rga_addr[4:0]. Data = rga_data[11:0]. Non-hits are ignored entirely.
- Push: a hit is written into the FIFO in the same cycle as an {idx, rgb} entry, in every state including INIT.
- Full FIFO: a hit is accepted if a pop occurs in the same cycle. Otherwise the hit is discarded, drop=1 for that cycle, and FIFO contents are unchanged.
- State INIT:
  - Each cycle registers tbl_wr=1, tbl_idx=counter, tbl_rgb=INIT_RGB, then increments the counter.
  - The sweep ignores pix_rd.
  - After index 31 is issued, go to RUN. init_busy falls in the cycle tbl_wr for index 31 is visible.
  - Entries 0..31 are written in exactly 32 consecutive cycles after reset deassertion.
- State RUN:
  - pop = !empty & (!DEFER_ON_RD | !pix_rd).
  - On pop, the next cycle shows tbl_wr=1 with the head entry's idx and rgb. Otherwise tbl_wr=0; tbl_idx and tbl_rgb hold their last values.
  - Latency with an empty FIFO and pix_rd low: hit at cycle N produces tbl_wr at N+1. Only a registered push→head path is allowed; there is no combinational rga→tbl path.
- Ordering: strict FIFO order. Repeated writes to the same index are all applied, with no coalescing, so the last write wins.
- Empty and push in the same cycle: the entry pops that cycle if the pop condition holds, giving N+1 latency.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap modulo; full/empty derived from the MSB compare.
- fifo_full is registered and reflects occupancy after the current cycle's push/pop.
- Reset mid-operation: everything returns to the reset state. Queued writes are lost and the sweep restarts at index 0.
- pix_rd held high indefinitely (DEFER_ON_RD=1): the FIFO fills; further hits raise drop; no table writes occur.

Decomposition:
- Shared package color_pkg:
  - NUM_COLORS=32, COLOR_BASE_WADDR=8'hC0.
  - Typedef color_wr_t {logic [4:0] idx; logic [11:0] rgb;}.
  - State enum {INIT, RUN}.
- One sub-module is natural: sync_fifo (parameterised width/depth, push/pop/full/empty). The controller instantiates it with width 17.

Test Plan:
- Reset release, pix_rd=0 → tbl_wr on 32 consecutive cycles, idx 0..31, rgb=12'h000; init_busy low afterwards; no drop.
- After init, rga_wr with addr=8'hC5, data=16'hFABC, pix_rd=0 → next cycle tbl_wr=1, idx=5, rgb=12'hABC; rga_addr=8'hBF or 8'hE0 → no tbl_wr.
- pix_rd=1 and hits to idx 1,2,3,4 → no tbl_wr and fifo_full=1. A 5th hit produces drop=1 for one cycle. pix_rd=0 then gives writes idx 1,2,3,4 on 4 consecutive cycles in order.
- FIFO full and pix_rd falling in the same cycle as a hit to idx 9 → no drop; idx 9 is written 5th.
- Hits during INIT (idx 7, rgb 12'h0F0) → applied after the sweep, so entry 7 ends at 12'h0F0, not INIT_RGB.
- rst_n asserted with 3 entries queued mid-drain → outputs go to reset values asynchronously; after release the sweep restarts at idx 0 and the queued entries are never written.
